// File: rtl/auto_shift_controller_if.sv
// Bundle of the rpm/gear signals exchanged between the RPM datapath
// side (master) and the automatic shift controller (slave).
interface auto_shift_controller_if;
    logic [31:0] rpm;
    logic        auto_en;
    logic [3:0]  man_gears;
    logic [3:0]  gears;
    logic [1:0]  gear_idx;
    logic        shifting;
    logic [15:0] shift_count;

    modport master (
        output rpm,
        output auto_en,
        output man_gears,
        input  gears,
        input  gear_idx,
        input  shifting,
        input  shift_count
    );

    modport slave (
        input  rpm,
        input  auto_en,
        input  man_gears,
        output gears,
        output gear_idx,
        output shifting,
        output shift_count
    );
endinterface

// File: rtl/auto_shift_controller.sv
// Automatic transmission controller. Watches rpm and steps the one-hot
// gear selection up or down one gear at a time. Every shift passes
// through a neutral clutch interval and then a settle lock-out. In manual
// mode the operator switches are passed through registered.
// CNT_W sets the width of the internal shift counter, which saturates at
// all ones and is zero-extended onto the 16-bit shift_count output; the
// default of 16 gives saturation at 16'hFFFF.
module auto_shift_controller #(
    parameter int unsigned UP_RPM     = 6000,
    parameter int unsigned DN_RPM     = 2000,
    parameter int unsigned CLUTCH_CYC = 25000000,
    parameter int unsigned SETTLE_CYC = 50000000,
    parameter int unsigned CNT_W      = 16
) (
    input logic                    clk,
    input logic                    reset_n,
    auto_shift_controller_if.slave bus
);

    typedef enum logic [1:0] {
        DRIVE,
        CLUTCH,
        SETTLE
    } state_t;

    localparam logic [31:0] UP_TH        = 32'(UP_RPM);
    localparam logic [31:0] DN_TH        = 32'(DN_RPM);
    localparam logic [31:0] CLUTCH_LOAD  = 32'(CLUTCH_CYC - 1);
    localparam logic [31:0] SETTLE_LOAD  = 32'(SETTLE_CYC - 1);
    localparam logic        SETTLE_SKIP  = (SETTLE_CYC <= 1);

    state_t             state;
    logic [31:0]        timer;
    logic [1:0]         target;
    logic [3:0]         gears_q;
    logic [1:0]         gear_idx_q;
    logic               shifting_q;
    logic [CNT_W-1:0]   count_q;

    logic [1:0]         man_idx;
    logic               up_req;
    logic               dn_req;

    // Index of the highest switch that is on; the upper gear wins.
    function automatic logic [1:0] highest_bit(input logic [3:0] v);
        if (v[3]) begin
            return 2'd3;
        end else if (v[2]) begin
            return 2'd2;
        end else if (v[1]) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Shift requests from the full-width unsigned rpm thresholds, gated so
    // that the top and bottom gears never try to leave the gear range.
    always_comb begin
        man_idx = highest_bit(bus.man_gears);
        up_req  = (bus.rpm >= UP_TH) && (gear_idx_q != 2'd3);
        dn_req  = (bus.rpm <= DN_TH) && (gear_idx_q != 2'd0);
    end

    // Shift sequencer: manual passthrough overrides everything, otherwise
    // DRIVE -> CLUTCH (neutral) -> SETTLE (lock-out) -> DRIVE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= DRIVE;
            timer      <= '0;
            target     <= '0;
            gears_q    <= 4'b0001;
            gear_idx_q <= '0;
            shifting_q <= 1'b0;
            count_q    <= '0;
        end else if (!bus.auto_en) begin
            state      <= DRIVE;
            timer      <= '0;
            shifting_q <= 1'b0;
            if (bus.man_gears == 4'b0000) begin
                gears_q <= 4'b0000;
            end else begin
                gears_q    <= onehot(man_idx);
                gear_idx_q <= man_idx;
            end
        end else begin
            case (state)
                DRIVE: begin
                    if (gears_q == 4'b0000) begin
                        gears_q <= onehot(gear_idx_q);
                    end else if (up_req) begin
                        target     <= 2'(gear_idx_q + 2'd1);
                        gears_q    <= 4'b0000;
                        shifting_q <= 1'b1;
                        timer      <= CLUTCH_LOAD;
                        state      <= CLUTCH;
                    end else if (dn_req) begin
                        target     <= 2'(gear_idx_q - 2'd1);
                        gears_q    <= 4'b0000;
                        shifting_q <= 1'b1;
                        timer      <= CLUTCH_LOAD;
                        state      <= CLUTCH;
                    end
                end
                CLUTCH: begin
                    if (timer != 32'd0) begin
                        timer <= timer - 32'd1;
                    end else begin
                        gears_q    <= onehot(target);
                        gear_idx_q <= target;
                        shifting_q <= 1'b0;
                        if (count_q != '1) begin
                            count_q <= count_q + 1'b1;
                        end
                        timer <= SETTLE_LOAD;
                        // A one-cycle lock-out is already covered by the
                        // engagement cycle itself, so go straight to DRIVE.
                        state <= SETTLE_SKIP ? DRIVE : SETTLE;
                    end
                end
                SETTLE: begin
                    // Leaving when the timer reaches 1 puts the first DRIVE
                    // evaluation exactly SETTLE_CYC cycles after engagement.
                    if (timer <= 32'd1) begin
                        timer <= '0;
                        state <= DRIVE;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                default: begin
                    state <= DRIVE;
                    timer <= '0;
                end
            endcase
        end
    end

    assign bus.gears       = gears_q;
    assign bus.gear_idx    = gear_idx_q;
    assign bus.shifting    = shifting_q;
    assign bus.shift_count = 16'(count_q);

endmodule

// File: tb/tb_auto_shift_controller.sv
// Directed bench for auto_shift_controller with UP_RPM=100, DN_RPM=20,
// CLUTCH_CYC=4, SETTLE_CYC=8 and a 3-bit shift counter so that
// saturation (at 7) is reachable in a short run.
module tb_auto_shift_controller;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    auto_shift_controller_if bus_if ();

    auto_shift_controller #(
        .UP_RPM     (100),
        .DN_RPM     (20),
        .CLUTCH_CYC (4),
        .SETTLE_CYC (8),
        .CNT_W      (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    // 10-time-unit clock; inputs change and outputs are sampled on negedges.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [31:0] rpm, input logic auto_en,
                                 input logic [3:0] man_gears);
        bus_if.rpm       = rpm;
        bus_if.auto_en   = auto_en;
        bus_if.man_gears = man_gears;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] gears,
                            input logic [1:0] idx, input logic shifting,
                            input logic [15:0] count);
        checkOutput({tag, ".gears"}, 32'(bus_if.gears), 32'(gears));
        checkOutput({tag, ".gear_idx"}, 32'(bus_if.gear_idx), 32'(idx));
        checkOutput({tag, ".shifting"}, 32'(bus_if.shifting), 32'(shifting));
        checkOutput({tag, ".shift_count"}, 32'(bus_if.shift_count), 32'(count));
    endtask

    // Linear directed sequence; comments give the posedge number relative
    // to the last input change.
    initial begin
        errors  = 0;
        checks  = 0;
        reset_n = 1'b0;
        applyStimulus(32'd50, 1'b1, 4'b0000);

        tick(1);
        checkAll("reset", 4'b0001, 2'd0, 1'b0, 16'd0);
        reset_n = 1'b1;

        // Idle in gear 0 with rpm between thresholds.
        for (int i = 0; i < 20; i++) begin
            tick(1);
            checkOutput("idle.gears", 32'(bus_if.gears), 32'h1);
        end
        checkAll("idle_end", 4'b0001, 2'd0, 1'b0, 16'd0);

        // rpm exactly at UP_RPM starts the first upshift.
        applyStimulus(32'd100, 1'b1, 4'b0000);
        tick(1);                                            // edge 1
        checkAll("up1_start", 4'b0000, 2'd0, 1'b1, 16'd0);
        applyStimulus(32'd150, 1'b1, 4'b0000);
        tick(3);                                            // edge 4
        checkAll("up1_neutral_last", 4'b0000, 2'd0, 1'b1, 16'd0);
        tick(1);                                            // edge 5
        checkAll("up1_engage", 4'b0010, 2'd1, 1'b0, 16'd1);
        tick(7);                                            // edge 12
        checkAll("up1_settle_last", 4'b0010, 2'd1, 1'b0, 16'd1);
        tick(1);                                            // edge 13
        checkAll("up2_start", 4'b0000, 2'd1, 1'b1, 16'd1);
        tick(4);                                            // edge 17
        checkAll("up2_engage", 4'b0100, 2'd2, 1'b0, 16'd2);
        tick(12);                                           // edge 29
        checkAll("up3_engage", 4'b1000, 2'd3, 1'b0, 16'd3);

        // Top gear with rpm far above UP_RPM never shifts.
        applyStimulus(32'd500, 1'b1, 4'b0000);
        tick(20);
        checkAll("top_hold", 4'b1000, 2'd3, 1'b0, 16'd3);

        // rpm exactly at DN_RPM steps down one gear.
        applyStimulus(32'd20, 1'b1, 4'b0000);
        tick(1);
        checkAll("dn_start", 4'b0000, 2'd3, 1'b1, 16'd3);
        tick(3);
        checkAll("dn_neutral_last", 4'b0000, 2'd3, 1'b1, 16'd3);
        tick(1);
        checkAll("dn_engage", 4'b0100, 2'd2, 1'b0, 16'd4);

        // One rpm above DN_RPM is not a downshift request.
        applyStimulus(32'd21, 1'b1, 4'b0000);
        tick(15);
        checkAll("dn_edge_hold", 4'b0100, 2'd2, 1'b0, 16'd4);

        // Abort an upshift by dropping to manual during CLUTCH.
        applyStimulus(32'd100, 1'b1, 4'b0000);
        tick(1);
        checkAll("abort_clutch", 4'b0000, 2'd2, 1'b1, 16'd4);
        applyStimulus(32'd100, 1'b0, 4'b0110);
        tick(1);
        checkAll("manual_0110", 4'b0100, 2'd2, 1'b0, 16'd4);
        applyStimulus(32'd100, 1'b0, 4'b0000);
        tick(1);
        checkAll("manual_neutral", 4'b0000, 2'd2, 1'b0, 16'd4);
        applyStimulus(32'd50, 1'b1, 4'b0000);
        tick(1);
        checkAll("auto_resume", 4'b0100, 2'd2, 1'b0, 16'd4);

        // Run the 3-bit shift counter into saturation.
        applyStimulus(32'd100, 1'b1, 4'b0000);
        tick(5);                                            // edge 5
        checkAll("sat_up", 4'b1000, 2'd3, 1'b0, 16'd5);
        applyStimulus(32'd20, 1'b1, 4'b0000);
        tick(24);                                           // edge 29
        checkAll("sat_reach", 4'b0010, 2'd1, 1'b0, 16'd7);
        tick(12);                                           // edge 41
        checkAll("sat_hold_dn", 4'b0001, 2'd0, 1'b0, 16'd7);
        applyStimulus(32'd100, 1'b1, 4'b0000);
        tick(12);                                           // edge 53
        checkAll("sat_hold_up", 4'b0010, 2'd1, 1'b0, 16'd7);

        // Asynchronous reset in the middle of SETTLE, between clock edges.
        tick(2);
        #2 reset_n = 1'b0;
        #1 checkAll("async_reset", 4'b0001, 2'd0, 1'b0, 16'd0);
        applyStimulus(32'd50, 1'b1, 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;
        tick(3);
        checkAll("post_reset", 4'b0001, 2'd0, 1'b0, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/auto_shift_controller.md
Name: auto_shift_controller

Overview:
- Automatic transmission controller that sequences gear changes for the RPM datapath.
- Watches the current rpm value and drives the one-hot gears bus consumed by the RPM determination block.
- Inserts a neutral "clutch" interval and a settle lock-out around every shift.
- In manual mode, passes operator switch gears through registered, replacing direct switch wiring in the top level.

Parameters:
- UP_RPM, 6000: unsigned rpm at or above which an upshift is requested.
- DN_RPM, 2000: unsigned rpm at or below which a downshift is requested. Must be < UP_RPM.
- CLUTCH_CYC, 25000000: cycles gears is held neutral (0) during a shift. Must be ≥ 1.
- SETTLE_CYC, 50000000: cycles after gear engagement during which no new shift is evaluated. Must be ≥ 1.

Ports:
- clk  in  1  50 MHz system clock
- reset_n  in  1  asynchronous reset, active low
- rpm  in  32  current unsigned rpm from the RPM datapath
- auto_en  in  1  1 = automatic shifting, 0 = manual
- man_gears  in  4  manual gear switches
- gears  out  4  one-hot gear to the datapath; 0 = neutral
- gear_idx  out  2  index of the engaged or last-engaged gear, 0..3
- shifting  out  1  high while in CLUTCH
- shift_count  out  16  completed automatic shifts; saturates at 16'hFFFF

Behaviour:
- Reset (async assert, sync release):
  - gears=4'b0001, gear_idx=0, shifting=0, shift_count=0.
  - State DRIVE, timer=0, target=0.
- All outputs are registered; every decision is visible one clock after the sampled inputs.
- rpm comparisons are unsigned, full 32-bit.
- Manual mode (auto_en=0), evaluated every cycle, overrides any FSM state:
  - If man_gears=0: gears=0, gear_idx holds its previous value.
  - Otherwise: gears=onehot(highest set bit of man_gears), gear_idx=that index.
  - State forced to DRIVE, timer cleared, shifting=0, shift_count unchanged.
- Auto mode FSM (states DRIVE, CLUTCH, SETTLE):
  - DRIVE:
    - If gears=0 (entered from manual neutral): gears<=onehot(gear_idx), no shift counted, remain DRIVE.
    - Else if rpm≥UP_RPM and gear_idx<3: target<=gear_idx+1, gears<=0, shifting<=1, timer<=CLUTCH_CYC-1, go to CLUTCH.
    - Else if rpm≤DN_RPM and gear_idx>0: same, with target<=gear_idx-1.
    - Otherwise hold.
  - CLUTCH:
    - gears=0, shifting=1. rpm is ignored.
    - When timer≠0: decrement.
    - When timer=0: gears<=onehot(target), gear_idx<=target, shifting<=0, shift_count<=sat(+1), timer<=SETTLE_CYC-1, go to SETTLE.
    - Neutral therefore lasts exactly CLUTCH_CYC cycles.
  - SETTLE:
    - gears holds, rpm is ignored.
    - Decrement timer; at 0 go to DRIVE. Next evaluation happens SETTLE_CYC cycles after engagement.
- Boundaries:
  - gear 3 with rpm≥UP_RPM: no shift. gear 0 with rpm≤DN_RPM: no shift.
  - Only one gear step per shift, regardless of how far rpm overshoots.
  - auto_en falling mid-CLUTCH/SETTLE: shift aborted, no count, manual values applied next cycle.
  - auto_en rising: FSM starts in DRIVE using current gear_idx; thresholds are evaluated that same cycle.
  - shift_count at FFFF stays FFFF.
  - reset_n asserted mid-shift: immediate return to reset values.

Test Plan (UP_RPM=100, DN_RPM=20, CLUTCH_CYC=4, SETTLE_CYC=8):
- Reset, auto_en=1, rpm=50 -> gears=0001, gear_idx=0, shifting=0, no change for 20 cycles.
- rpm stepped to 100 -> next cycle gears=0, shifting=1 for 4 cycles; then gears=0010, gear_idx=1, shift_count=1; rpm held at 150 -> next upshift starts exactly 8 cycles after engagement; gears=1000 after three shifts; further rpm=500 -> no shift, count=3.
- From gear 3, rpm=20 -> downshift to 0100 after 4 neutral cycles; rpm=21 in gear 2 -> no shift.
- auto_en=0 during CLUTCH with man_gears=0110 -> next cycle gears=0100, gear_idx=2, shifting=0, count unchanged; man_gears=0 -> gears=0, gear_idx stays 2; auto_en=1, rpm=50 -> gears=0100 next cycle.
- reset_n pulsed low mid-SETTLE -> outputs return to reset values asynchronously, without waiting for a clock edge.
- Force shift_count to FFFF via repeated shifts (bench-reduced width or long run) -> a further shift leaves shift_count=FFFF.
